timer_period_counter: RTL and testbench

Period counter for the APB advanced-timer channel. It sits downstream of the timer control block and consumes that block's `ctrl_*` outputs. It produces the counter value, a period-end event, and the `cnt_update` handshake that clears the controller's pending-update status bit. Start, end and mode are double-buffered in shadow registers. A software update takes effect immediately while the counter is idle, or at the next period boundary while it is running.

---
 rtl/timer_period_counter.sv | 182 ++++++++++++++++++
 tb/tb_timer_period_counter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/timer_period_counter.sv
// timer_period_counter
// Period counter for one advanced-timer channel. It consumes the timer
// controller's ctrl_* strobes and produces the count value, the count
// direction, a period-end pulse, and the cnt_update pulse that clears the
// controller's pending-update bit.
// Start, end and mode are double-buffered. A software update is loaded into
// the shadows at once while the counter is idle or being reloaded. While the
// counter runs, the update waits for the next period end.
// Optional feature: define TIMER_CNT_ONESHOT_EN to add cfg_oneshot_i/done_o.
// In that build the counter freezes after its first period end.
module timer_period_counter #(
  parameter int NUM_BITS = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ctrl_active_i,
  input  logic                ctrl_rst_i,
  input  logic                ctrl_cnt_upd_i,
  input  logic                tick_i,
  input  logic [NUM_BITS-1:0] cfg_start_i,
  input  logic [NUM_BITS-1:0] cfg_end_i,
  input  logic                cfg_sawtooth_i,
`ifdef TIMER_CNT_ONESHOT_EN
  input  logic                cfg_oneshot_i,
  output logic                done_o,
`endif
  output logic [NUM_BITS-1:0] counter_o,
  output logic                dir_o,
  output logic                end_o,
  output logic                cnt_update_o
);

  logic [NUM_BITS-1:0] counter_reg, counter_next;
  logic                dir_reg, dir_next;
  logic                end_reg, end_next;
  logic                cnt_update_reg, cnt_update_next;
  logic                upd_pend_reg, upd_pend_next;
  logic [NUM_BITS-1:0] s_start_reg, s_start_next;
  logic [NUM_BITS-1:0] s_end_reg, s_end_next;
  logic                s_saw_reg, s_saw_next;

  logic                eff_active;
  logic                step;
  logic                upd_req;
  logic                apply;
  logic                period_end;
  logic [NUM_BITS-1:0] step_cnt;
  logic                step_dir;
  logic                step_end;

`ifdef TIMER_CNT_ONESHOT_EN
  logic s_oneshot_reg, s_oneshot_next;
  logic done_reg, done_next;
  // A finished one-shot counter behaves as idle, so pending updates can still land.
  assign eff_active = ctrl_active_i && !done_reg;
`else
  assign eff_active = ctrl_active_i;
`endif

  assign step    = eff_active && tick_i;
  assign upd_req = upd_pend_reg || ctrl_cnt_upd_i;

  // Compute what one count step would produce from the current shadows.
  always_comb begin
    step_cnt = counter_reg;
    step_dir = dir_reg;
    step_end = 1'b0;
    if ((s_start_reg == s_end_reg) && (counter_reg == s_end_reg)) begin
      // Zero-length period: hold at the threshold, and every step ends a period.
      step_end = 1'b1;
      step_dir = 1'b0;
    end else if (s_saw_reg) begin
      step_dir = 1'b0;
      if (counter_reg == s_end_reg) begin
        step_cnt = s_start_reg;
        step_end = 1'b1;
      end else begin
        step_cnt = counter_reg + 1'b1;
      end
    end else if (!dir_reg) begin
      if (counter_reg == s_end_reg) begin
        step_dir = 1'b1;
        step_cnt = counter_reg - 1'b1;
      end else begin
        step_cnt = counter_reg + 1'b1;
      end
    end else begin
      if (counter_reg == s_start_reg) begin
        step_dir = 1'b0;
        step_cnt = counter_reg + 1'b1;
        step_end = 1'b1;
      end else begin
        step_cnt = counter_reg - 1'b1;
      end
    end
  end

  // A controller reload takes priority over stepping, so it suppresses the period end.
  assign period_end = step && !ctrl_rst_i && step_end;
  assign apply      = upd_req && (!eff_active || ctrl_rst_i || period_end);

  // Select next counter state, output pulses, pending flag and shadow contents.
  always_comb begin
    counter_next    = counter_reg;
    dir_next        = dir_reg;
    end_next        = 1'b0;
    cnt_update_next = apply;
    upd_pend_next   = apply ? 1'b0 : upd_req;
    s_start_next    = apply ? cfg_start_i : s_start_reg;
    s_end_next      = apply ? cfg_end_i : s_end_reg;
    s_saw_next      = apply ? cfg_sawtooth_i : s_saw_reg;
    if (ctrl_rst_i) begin
      counter_next = apply ? cfg_start_i : s_start_reg;
      dir_next     = 1'b0;
    end else if (step) begin
      end_next = step_end;
      if (apply && step_end) begin
        // The new period starts from the freshly loaded start value.
        counter_next = cfg_start_i;
        dir_next     = 1'b0;
      end else begin
        counter_next = step_cnt;
        dir_next     = step_dir;
      end
    end
  end

`ifdef TIMER_CNT_ONESHOT_EN
  // The one-shot latch is set at the first period end and is cleared by a controller reload.
  always_comb begin
    s_oneshot_next = apply ? cfg_oneshot_i : s_oneshot_reg;
    done_next      = done_reg;
    if (ctrl_rst_i) begin
      done_next = 1'b0;
    end else if (period_end && s_oneshot_reg) begin
      done_next = 1'b1;
    end
  end

  // Registers for the one-shot shadow and the done state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s_oneshot_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      s_oneshot_reg <= s_oneshot_next;
      done_reg      <= done_next;
    end
  end

  assign done_o = done_reg;
`endif

  // Registers for the counter state, output pulses, pending flag and shadows.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter_reg    <= '0;
      dir_reg        <= 1'b0;
      end_reg        <= 1'b0;
      cnt_update_reg <= 1'b0;
      upd_pend_reg   <= 1'b0;
      s_start_reg    <= '0;
      s_end_reg      <= '0;
      s_saw_reg      <= 1'b1;
    end else begin
      counter_reg    <= counter_next;
      dir_reg        <= dir_next;
      end_reg        <= end_next;
      cnt_update_reg <= cnt_update_next;
      upd_pend_reg   <= upd_pend_next;
      s_start_reg    <= s_start_next;
      s_end_reg      <= s_end_next;
      s_saw_reg      <= s_saw_next;
    end
  end

  assign counter_o    = counter_reg;
  assign dir_o        = dir_reg;
  assign end_o        = end_reg;
  assign cnt_update_o = cnt_update_reg;

endmodule

// File: tb/tb_timer_period_counter.sv
// Testbench for timer_period_counter.
// The stimulus process queues the expected outputs for every cycle it drives.
// The monitor process pops one entry after each clock edge and compares it
// against the DUT outputs.
module tb_timer_period_counter;

  localparam int NB = 16;

  typedef struct {
    logic [NB-1:0] cnt;
    logic          dir;
    logic          en;
    logic          upd;
    string         name;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ctrl_active_i = 1'b0;
  logic          ctrl_rst_i = 1'b0;
  logic          ctrl_cnt_upd_i = 1'b0;
  logic          tick_i = 1'b0;
  logic [NB-1:0] cfg_start_i = '0;
  logic [NB-1:0] cfg_end_i = '0;
  logic          cfg_sawtooth_i = 1'b1;
  logic [NB-1:0] counter_o;
  logic          dir_o;
  logic          end_o;
  logic          cnt_update_o;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  timer_period_counter #(.NUM_BITS(NB)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .ctrl_active_i  (ctrl_active_i),
    .ctrl_rst_i     (ctrl_rst_i),
    .ctrl_cnt_upd_i (ctrl_cnt_upd_i),
    .tick_i         (tick_i),
    .cfg_start_i    (cfg_start_i),
    .cfg_end_i      (cfg_end_i),
    .cfg_sawtooth_i (cfg_sawtooth_i),
    .counter_o      (counter_o),
    .dir_o          (dir_o),
    .end_o          (end_o),
    .cnt_update_o   (cnt_update_o)
  );

  // Drive one cycle of inputs on the falling edge, and queue the outputs expected after the next rising edge.
  task automatic drive(input string name, input logic rst, input logic act, input logic crst,
                       input logic upd, input logic tick, input int cs, input int ce, input logic saw,
                       input int ecnt, input logic edir, input logic eend, input logic eupd);
    exp_t e;
    @(negedge clk_i);
    rst_i          = rst;
    ctrl_active_i  = act;
    ctrl_rst_i     = crst;
    ctrl_cnt_upd_i = upd;
    tick_i         = tick;
    cfg_start_i    = NB'(cs);
    cfg_end_i      = NB'(ce);
    cfg_sawtooth_i = saw;
    e.cnt  = NB'(ecnt);
    e.dir  = edir;
    e.en   = eend;
    e.upd  = eupd;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: compare the DUT outputs with the next queued expectation shortly after each rising edge.
  always @(posedge clk_i) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (counter_o !== e.cnt || dir_o !== e.dir || end_o !== e.en || cnt_update_o !== e.upd) begin
        fails++;
        $display("[TB] FAIL %s: got cnt=%0d dir=%0b end=%0b upd=%0b, want cnt=%0d dir=%0b end=%0b upd=%0b",
                 e.name, counter_o, dir_o, end_o, cnt_update_o, e.cnt, e.dir, e.en, e.upd);
      end else begin
        $display("[TB] ok %s: cnt=%0d dir=%0b end=%0b upd=%0b", e.name, counter_o, dir_o, end_o, cnt_update_o);
      end
    end
  end

  initial begin
    //    name          rst act crs upd tck cs ce saw   cnt dir end upd
    drive("reset",        1, 0, 0, 0, 0, 0, 0, 1,     0, 0, 0, 0);
    // Sawtooth test. Idle load of 2..5, reload, then run through one wrap.
    drive("idle_upd",     0, 0, 0, 1, 0, 2, 5, 1,     0, 0, 0, 1);
    drive("idle_quiet",   0, 0, 0, 0, 0, 2, 5, 1,     0, 0, 0, 0);
    drive("saw_reload",   0, 1, 1, 0, 0, 2, 5, 1,     2, 0, 0, 0);
    drive("saw_3",        0, 1, 0, 0, 1, 2, 5, 1,     3, 0, 0, 0);
    drive("saw_4",        0, 1, 0, 0, 1, 2, 5, 1,     4, 0, 0, 0);
    drive("saw_5",        0, 1, 0, 0, 1, 2, 5, 1,     5, 0, 0, 0);
    drive("saw_wrap",     0, 1, 0, 0, 1, 2, 5, 1,     2, 0, 1, 0);
    drive("saw_3b",       0, 1, 0, 0, 1, 2, 5, 1,     3, 0, 0, 0);
    // Running update: request end=7 at count 3. It applies only at the wrap.
    drive("run_req",      0, 1, 0, 1, 1, 2, 7, 1,     4, 0, 0, 0);
    drive("run_5",        0, 1, 0, 0, 1, 2, 7, 1,     5, 0, 0, 0);
    drive("run_apply",    0, 1, 0, 0, 1, 2, 7, 1,     2, 0, 1, 1);
    drive("run_3",        0, 1, 0, 0, 1, 2, 7, 1,     3, 0, 0, 0);
    drive("run_4",        0, 1, 0, 0, 1, 2, 7, 1,     4, 0, 0, 0);
    drive("run_5b",       0, 1, 0, 0, 1, 2, 7, 1,     5, 0, 0, 0);
    drive("run_6",        0, 1, 0, 0, 1, 2, 7, 1,     6, 0, 0, 0);
    drive("run_7",        0, 1, 0, 0, 1, 2, 7, 1,     7, 0, 0, 0);
    drive("run_wrap",     0, 1, 0, 0, 1, 2, 7, 1,     2, 0, 1, 0);
    drive("no_tick",      0, 1, 0, 0, 0, 2, 7, 1,     2, 0, 0, 0);
    drive("tick_inact",   0, 0, 0, 0, 1, 2, 7, 1,     2, 0, 0, 0);
    // Triangle test over 0..3.
    drive("tri_load",     0, 0, 0, 1, 0, 0, 3, 0,     2, 0, 0, 1);
    drive("tri_reload",   0, 1, 1, 0, 0, 0, 3, 0,     0, 0, 0, 0);
    drive("tri_1",        0, 1, 0, 0, 1, 0, 3, 0,     1, 0, 0, 0);
    drive("tri_2",        0, 1, 0, 0, 1, 0, 3, 0,     2, 0, 0, 0);
    drive("tri_3",        0, 1, 0, 0, 1, 0, 3, 0,     3, 0, 0, 0);
    drive("tri_turn",     0, 1, 0, 0, 1, 0, 3, 0,     2, 1, 0, 0);
    drive("tri_1d",       0, 1, 0, 0, 1, 0, 3, 0,     1, 1, 0, 0);
    drive("tri_0d",       0, 1, 0, 0, 1, 0, 3, 0,     0, 1, 0, 0);
    drive("tri_end",      0, 1, 0, 0, 1, 0, 3, 0,     1, 0, 1, 0);
    // Degenerate case start == end: the counter holds and every step is a period end.
    drive("deg_load",     0, 0, 0, 1, 0, 4, 4, 1,     1, 0, 0, 1);
    drive("deg_reload",   0, 1, 1, 0, 0, 4, 4, 1,     4, 0, 0, 0);
    drive("deg_step1",    0, 1, 0, 0, 1, 4, 4, 1,     4, 0, 1, 0);
    drive("deg_step2",    0, 1, 0, 0, 1, 4, 4, 1,     4, 0, 1, 0);
    // Start sequence: reload, update and active arrive together, so the new start loads at once.
    drive("start_seq",    0, 1, 1, 1, 1, 9, 12, 1,    9, 0, 0, 1);
    drive("start_10",     0, 1, 0, 0, 1, 9, 12, 1,   10, 0, 0, 0);
    // rst_i arrives with an update pending, so the pending update is discarded.
    drive("pend_req",     0, 1, 0, 1, 1, 3, 12, 1,   11, 0, 0, 0);
    drive("mid_reset",    1, 1, 0, 0, 1, 3, 12, 1,    0, 0, 0, 0);
    drive("post_rst_1",   0, 0, 0, 0, 0, 3, 12, 1,    0, 0, 0, 0);
    drive("post_rst_2",   0, 0, 0, 0, 0, 3, 12, 1,    0, 0, 0, 0);

    // Bounded wait for the monitor to drain the queue.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk_i);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
